// File: rtl/fiat_25519_carry_square_carry_chain.sv
// ---------------------------------------------------------------------------
// fiat_25519_carry_square_carry_chain
//
// Purpose:
//   Final stage of the 2^25.5-radix squaring datapath for GF(2^255-19).
//   Ten column sums arrive one per beat, limb 0 first. Each sum is added to
//   the running carry and split into a limb (26 bits for even limbs,
//   25 bits for odd limbs) plus a new carry. Once all ten sums are in, the
//   top carry is folded back into limb 0 as carry*19 (2^255 = 19 mod p).
//   Any overflow from limb 0 moves into limb 1. The ten reduced limbs are
//   then streamed out.
//
// Ports:
//   ap_clk     clock, all state updates on the rising edge
//   ap_rst     synchronous active-high reset
//   in_valid   column-sum beat valid
//   in_ready   beat accepted this cycle (high only while accumulating)
//   in_data    column sum for the current limb index (ACC_W bits)
//   out_valid  reduced limb valid
//   out_ready  consumer accepts the limb this cycle
//   out_data   reduced limb (LIMB_W bits, odd limbs zero-extended)
//   out_last   high together with limb NLIMBS-1
//   busy       high while folding or emitting
// ---------------------------------------------------------------------------
module fiat_25519_carry_square_carry_chain #(
  parameter int ACC_W  = 64,
  parameter int LIMB_W = 26,
  parameter int NLIMBS = 10,
  parameter int FOLD_K = 19
) (
  input  logic              ap_clk,
  input  logic              ap_rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ACC_W-1:0]  in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [LIMB_W-1:0] out_data,
  output logic              out_last,
  output logic              busy
);

  // The carry out of a 25-bit split of an (ACC_W+1)-bit sum needs ACC_W-24 bits.
  localparam int CARRY_W = ACC_W - 24;
  localparam int T_W     = ACC_W + 1;
  // Width of limb0 + carry*FOLD_K. It holds exactly for the default parameters.
  localparam int FOLD_W  = 46;
  localparam int IDX_W   = $clog2(NLIMBS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NLIMBS - 1);

  typedef enum logic [1:0] {
    S_ACCUM,
    S_FOLD,
    S_EMIT
  } state_t;

  state_t              state_q, state_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [CARRY_W-1:0]  carry_q, carry_d;
  logic [LIMB_W-1:0]   limb_q [NLIMBS];
  logic [LIMB_W-1:0]   limb_d [NLIMBS];

  logic [T_W-1:0]      t_sum;
  logic [FOLD_W-1:0]   fold_sum;

  // NOTE: every signal this block writes gets a default first. A path that
  // leaves a signal unassigned would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    limb_d  = limb_q;

    // The ACC_W+1 bit sum keeps the addition exact for any input and carry.
    t_sum    = {1'b0, in_data} + T_W'(carry_q);
    fold_sum = FOLD_W'(limb_q[0]) + FOLD_W'(carry_q) * FOLD_W'(FOLD_K);

    unique case (state_q)
      S_ACCUM: begin
        if (in_valid) begin
          if (idx_q[0]) begin
            // Odd limbs keep 25 bits.
            limb_d[idx_q] = {1'b0, t_sum[LIMB_W-2:0]};
            carry_d       = CARRY_W'(t_sum >> (LIMB_W - 1));
          end else begin
            limb_d[idx_q] = t_sum[LIMB_W-1:0];
            carry_d       = CARRY_W'(t_sum >> LIMB_W);
          end
          if (idx_q == LAST_IDX) begin
            idx_d   = '0;
            state_d = S_FOLD;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end

      S_FOLD: begin
        // After the fold, limb 1 stays below 2^25 + 2^20, so it fits in LIMB_W.
        limb_d[0] = fold_sum[LIMB_W-1:0];
        limb_d[1] = limb_q[1] + LIMB_W'(fold_sum >> LIMB_W);
        carry_d   = '0;
        idx_d     = '0;
        state_d   = S_EMIT;
      end

      S_EMIT: begin
        if (out_ready) begin
          if (idx_q == LAST_IDX) begin
            idx_d   = '0;
            state_d = S_ACCUM;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end

      default: state_d = S_ACCUM;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only. All flops see
  // their pre-edge values, which avoids simulation races between processes.
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      state_q <= S_ACCUM;
      idx_q   <= '0;
      carry_q <= '0;
      // NOTE: the limb registers are a small register file, not RAM. They are
      // cleared on reset so out_data and a discarded partial transaction
      // never leak stale values.
      for (int i = 0; i < NLIMBS; i++) begin
        limb_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      for (int i = 0; i < NLIMBS; i++) begin
        limb_q[i] <= limb_d[i];
      end
    end
  end

  assign in_ready  = (state_q == S_ACCUM);
  assign out_valid = (state_q == S_EMIT);
  assign busy      = (state_q != S_ACCUM);
  assign out_last  = out_valid && (idx_q == LAST_IDX);
  assign out_data  = out_valid ? limb_q[idx_q] : '0;

endmodule
